interp_scheduler: RTL and testbench
===================================

INTERP_SCHEDULER -- requirements
Module: interp_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter RATIO, default 10, interpolation ratio (output samples per input sample).
REQ-003 Parameter DIV_10X, default 100, clk cycles per clk_en_10x period (48 MHz / 480 kHz).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  run control; low forces IDLE.
REQ-007 sample_in  in  WIDTH  upstream source sample, sampled on clk_en.
REQ-008 end_stage  in  1  interpolator frame-complete flag, rising edge significant.
REQ-009 sample_y  in  RATIO*WIDTH  interpolator outputs, y0 in LSBs.
REQ-010 clear_err  in  1  clears sticky error flags.
REQ-011 clk_en  out  1  one-cycle 48 kHz strobe.
REQ-012 clk_en_10x  out  1  one-cycle 480 kHz strobe.
REQ-013 sample_x0  out  WIDTH  previous input sample (older).
REQ-014 sample_x1  out  WIDTH  current input sample.
REQ-015 sample_out  out  WIDTH  serialized interpolated sample.
REQ-016 sample_valid  out  1  one-cycle strobe, sample_out updated.
REQ-017 underrun  out  1  sticky: tick with no sample available.
REQ-018 overrun  out  1  sticky: new frame arrived with unconsumed samples.

Function
REQ-019 Divider cnt counts 0..DIV_10X-1 while enable=1; clk_en_10x=1 in the cycle cnt==DIV_10X-1, then cnt wraps to 0.
REQ-020 Phase counter ph counts 0..RATIO-1 on each clk_en_10x; clk_en=1 coincident with clk_en_10x when ph==RATIO-1 (period RATIO*DIV_10X cycles, always aligned to a 10x strobe).
REQ-021 Strobes registered; first clk_en_10x occurs DIV_10X cycles after enable rises; first clk_en after RATIO*DIV_10X cycles.
REQ-022 On the cycle after clk_en: sample_x1 <= sample_in, sample_x0 <= old sample_x1.
REQ-023 end_stage edge-detected internally (registered previous value); one capture per rising edge; level-high held does not recapture.
REQ-024 On capture: buffer <= sample_y, idx <= 0, remaining <= RATIO.
REQ-025 FSM states IDLE, PRIME, STREAM; IDLE->PRIME when enable=1; PRIME->STREAM on first capture; any state->IDLE when enable=0.
REQ-026 STREAM, on clk_en_10x with remaining>0: sample_out <= buffer[idx], sample_valid=1 next cycle, idx++, remaining--.
REQ-027 STREAM, on clk_en_10x with remaining==0: underrun <= 1, sample_out holds, sample_valid stays 0.
REQ-028 PRIME: clk_en_10x never sets underrun; sample_valid stays 0.
REQ-029 Capture and clk_en_10x in the same cycle: consumption of old frame occurs first; overrun set only if remaining>1 before that cycle; new frame then loaded with idx=0.
REQ-030 Capture with remaining>0 (non-simultaneous): overrun <= 1, new frame replaces old.
REQ-031 clear_err=1 clears underrun/overrun; a setting event in the same cycle wins.
REQ-032 enable=0: cnt, ph, idx, remaining cleared; strobes and sample_valid 0; sample_x0/x1/sample_out and error flags held.

Reset
REQ-033 reset=1 drives every counter, buffer entry, sample_x0, sample_x1, sample_out to 0, all strobes and flags to 0, FSM to IDLE; reset overrides enable.
REQ-034 Reset mid-frame discards buffered samples; no sample_valid in the cycle after reset deasserts.

Structure
REQ-035 Package gf_audio_pkg holds WIDTH, RATIO, DIV_10X defaults and the FSM state encoding.
REQ-036 Divider/phase logic in sub-module strobe_gen (outputs clk_en, clk_en_10x); serializer and FSM in top level.

Verification
REQ-037 Strobe timing: enable after reset, run 5000 cycles -> clk_en_10x at cycles 100,200,...; clk_en at 1000,2000,... coincident with clk_en_10x.
REQ-038 History: sample_in ramps 1,2,3 per clk_en -> after third clk_en, sample_x0=2, sample_x1=3.
REQ-039 Streaming: frame y0..y9=10..19 captured, end_stage once per 1000 cycles -> sample_out 10..19 one per 10x tick, no flags.
REQ-040 Underrun: one frame then no end_stage -> 10 valid outputs, 11th tick sets underrun, sample_out holds 19; clear_err clears it.
REQ-041 Overrun: second end_stage after 3 ticks -> overrun=1, next output is new frame y0; simultaneous capture with 10th tick -> overrun stays 0.
REQ-042 Reset/enable mid-frame: reset at tick 5 -> all outputs 0, FSM IDLE, first valid only after new capture.

Source files
------------

// File: rtl/gf_audio_pkg.sv
// Shared defaults and encodings for the audio interpolation scheduler.
package gf_audio_pkg;

    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned RATIO_DEF   = 10;
    localparam int unsigned DIV_10X_DEF = 100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } sched_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interp_scheduler_strobe_gen.sv
// Clock-enable generator: 10x strobe every DIV_10X cycles, base strobe every RATIO 10x strobes.
module strobe_gen
    import gf_audio_pkg::*;
#(
    parameter int unsigned RATIO   = RATIO_DEF,
    parameter int unsigned DIV_10X = DIV_10X_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic clk_en,
    output logic clk_en_10x
);

    localparam int unsigned CNT_W = cnt_width(DIV_10X);
    localparam int unsigned PH_W  = cnt_width(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_10X - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q,  ph_d;
    logic             en_q,  en_d;
    logic             en10_q, en10_d;

    // Base strobe only ever fires together with a 10x strobe.
    always_comb begin
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        en_d   = 1'b0;
        en10_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
            ph_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            en10_d = 1'b1;
            if (ph_q == PH_LAST) begin
                ph_d = '0;
                en_d = 1'b1;
            end else begin
                ph_d = ph_q + PH_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            ph_q   <= '0;
            en_q   <= 1'b0;
            en10_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            en_q   <= en_d;
            en10_q <= en10_d;
        end
    end

    assign clk_en     = en_q;
    assign clk_en_10x = en10_q;

endmodule

// File: rtl/interp_scheduler.sv
// Interpolation scheduler: input sample history, frame capture on end_stage and
// serialization of interpolated samples on the 10x strobe with under/overrun tracking.
module interp_scheduler
    import gf_audio_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned RATIO   = RATIO_DEF,
    parameter int unsigned DIV_10X = DIV_10X_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       sample_in,
    input  logic                   end_stage,
    input  logic [RATIO*WIDTH-1:0] sample_y,
    input  logic                   clear_err,
    output logic                   clk_en,
    output logic                   clk_en_10x,
    output logic [WIDTH-1:0]       sample_x0,
    output logic [WIDTH-1:0]       sample_x1,
    output logic [WIDTH-1:0]       sample_out,
    output logic                   sample_valid,
    output logic                   underrun,
    output logic                   overrun
);

    localparam int unsigned IDX_W = cnt_width(RATIO);
    localparam int unsigned REM_W = $clog2(RATIO + 1);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(RATIO);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] frame_q [RATIO];
    logic [WIDTH-1:0] frame_d [RATIO];
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] x0_q, x0_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic             valid_q, valid_d;
    logic             und_q, und_d;
    logic             ovr_q, ovr_d;
    logic             es_q;
    logic             capture_c;

    strobe_gen #(
        .RATIO   (RATIO),
        .DIV_10X (DIV_10X)
    ) u_strobe_gen (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clk_en     (clk_en),
        .clk_en_10x (clk_en_10x)
    );

    // Frames are only accepted once the scheduler has left IDLE.
    assign capture_c = end_stage & ~es_q & (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        frame_d = frame_q;
        out_d   = out_q;
        valid_d = 1'b0;
        x0_d    = x0_q;
        x1_d    = x1_q;
        und_d   = und_q;
        ovr_d   = ovr_q;

        if (clear_err) begin
            und_d = 1'b0;
            ovr_d = 1'b0;
        end

        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            rem_d   = '0;
        end else begin
            if (clk_en) begin
                x1_d = sample_in;
                x0_d = x1_q;
            end

            case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (capture_c) state_d = ST_STREAM;
                ST_STREAM: begin
                    if (clk_en_10x) begin
                        if (rem_q != '0) begin
                            out_d   = frame_q[idx_q];
                            valid_d = 1'b1;
                            idx_d   = idx_q + IDX_W'(1);
                            rem_d   = rem_q - REM_W'(1);
                        end else begin
                            und_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Old frame is consumed first; only samples still left afterwards count as lost.
            if (capture_c) begin
                if (rem_d != '0) ovr_d = 1'b1;
                for (int unsigned i = 0; i < RATIO; i++) begin
                    frame_d[i] = sample_y[i*WIDTH +: WIDTH];
                end
                idx_d = '0;
                rem_d = REM_FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            frame_q <= '{default: '0};
            out_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            valid_q <= 1'b0;
            und_q   <= 1'b0;
            ovr_q   <= 1'b0;
            es_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            frame_q <= frame_d;
            out_q   <= out_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            valid_q <= valid_d;
            und_q   <= und_d;
            ovr_q   <= ovr_d;
            es_q    <= end_stage;
        end
    end

    assign sample_x0    = x0_q;
    assign sample_x1    = x1_q;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign underrun     = und_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_interp_scheduler.sv
// Scoreboard bench for interp_scheduler: directed frames, expected samples queued, monitor compares.
module tb_interp_scheduler;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RATIO = 10;
    localparam int unsigned DIV   = 100;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [WIDTH-1:0]       sample_in;
    logic                   end_stage;
    logic [RATIO*WIDTH-1:0] sample_y;
    logic                   clear_err;
    logic                   clk_en;
    logic                   clk_en_10x;
    logic [WIDTH-1:0]       sample_x0;
    logic [WIDTH-1:0]       sample_x1;
    logic [WIDTH-1:0]       sample_out;
    logic                   sample_valid;
    logic                   underrun;
    logic                   overrun;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] mon_exp;
    int n_err = 0;
    int n_chk = 0;
    int m_err = 0;
    int m_chk = 0;

    always #5 clk = ~clk;

    interp_scheduler #(
        .WIDTH   (WIDTH),
        .RATIO   (RATIO),
        .DIV_10X (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_in    (sample_in),
        .end_stage    (end_stage),
        .sample_y     (sample_y),
        .clear_err    (clear_err),
        .clk_en       (clk_en),
        .clk_en_10x   (clk_en_10x),
        .sample_x0    (sample_x0),
        .sample_x1    (sample_x1),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    // Monitor: every presented sample must match the head of the expected queue.
    always @(negedge clk) begin
        if (sample_valid) begin
            m_chk++;
            if (exp_q.size() == 0) begin
                m_err++;
                $display("FAIL unexpected_valid: got sample_out=%0d, required no output", sample_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sample_out !== mon_exp) begin
                    m_err++;
                    $display("FAIL sample_out: got %0d, required %0d", sample_out, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_tick();
        for (int k = 0; k < 250; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (clk_en_10x) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL tick_timeout: got no clk_en_10x in 250 cycles, required one");
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic load_y(input int base);
        for (int i = 0; i < RATIO; i++) sample_y[i*WIDTH +: WIDTH] = WIDTH'(base + i);
    endtask

    task automatic push_exp(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) exp_q.push_back(WIDTH'(base + i));
    endtask

    // end_stage held high three cycles: a held level must not recapture.
    task automatic pulse_frame(input int base);
        repeat (10) @(negedge clk);
        load_y(base);
        end_stage = 1'b1;
        repeat (3) @(negedge clk);
        end_stage = 1'b0;
    endtask

    initial begin
        int first;
        int strobes;
        reset     = 1'b1;
        enable    = 1'b0;
        sample_in = '0;
        end_stage = 1'b0;
        sample_y  = '0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_sample_out", sample_out, 0);
        chk("rst_x0", sample_x0, 0);
        chk("rst_x1", sample_x1, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_clk_en_10x", clk_en_10x, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_overrun", overrun, 0);

        // Strobe timing and input history
        reset     = 1'b0;
        enable    = 1'b1;
        sample_in = 8'd1;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("clk_en_10x_timing", clk_en_10x, int'(n % 100 == 0));
            chk("clk_en_timing", clk_en, int'(n % 1000 == 0));
            if (n % 1000 == 1 && n > 1) begin
                chk("hist_x1", sample_x1, n / 1000);
                chk("hist_x0", sample_x0, n / 1000 - 1);
                sample_in = WIDTH'(n / 1000 + 1);
            end
        end
        chk("prime_no_underrun", underrun, 0);

        // Streaming: two back-to-back frames
        wait_ticks(1);
        push_exp(10, 10);
        pulse_frame(10);
        wait_ticks(10);
        push_exp(20, 10);
        pulse_frame(20);
        wait_ticks(10);
        @(negedge clk);
        chk("stream_overrun", overrun, 0);
        chk("stream_underrun", underrun, 0);

        // Underrun on the next empty tick, sample_out holds
        wait_tick();
        @(negedge clk);
        chk("underrun_set", underrun, 1);
        chk("underrun_hold_out", sample_out, 29);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("underrun_cleared", underrun, 0);
        wait_tick();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_vs_set", underrun, 1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("underrun_cleared2", underrun, 0);

        // Overrun: new frame after three ticks replaces the old one
        push_exp(30, 3);
        pulse_frame(30);
        chk("first_frame_no_overrun", overrun, 0);
        wait_ticks(3);
        push_exp(40, 10);
        pulse_frame(40);
        chk("overrun_set", overrun, 1);
        chk("overrun_no_underrun", underrun, 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Capture coincident with the tick that drains the last sample
        wait_ticks(9);
        wait_tick();
        load_y(50);
        end_stage = 1'b1;
        push_exp(50, 5);
        repeat (3) @(negedge clk);
        end_stage = 1'b0;
        chk("overrun_simultaneous", overrun, 0);
        chk("underrun_simultaneous", underrun, 0);

        // Reset mid-frame, enable still high
        wait_ticks(5);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_sample_out", sample_out, 0);
        chk("mid_rst_x0", sample_x0, 0);
        chk("mid_rst_x1", sample_x1, 0);
        chk("mid_rst_valid", sample_valid, 0);
        chk("mid_rst_clk_en_10x", clk_en_10x, 0);
        chk("mid_rst_clk_en", clk_en, 0);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (clk_en_10x) begin
                first = i;
                break;
            end
        end
        chk("first_tick_after_reset", first, 100);
        wait_ticks(2);
        chk("post_rst_prime_no_underrun", underrun, 0);
        push_exp(60, 10);
        pulse_frame(60);
        wait_ticks(10);
        repeat (2) @(negedge clk);
        chk("post_rst_overrun", overrun, 0);
        chk("post_rst_underrun", underrun, 0);
        chk("post_rst_last_out", sample_out, 69);

        // Disable: strobes stop, outputs hold
        enable  = 1'b0;
        strobes = 0;
        repeat (300) begin
            @(negedge clk);
            if (clk_en_10x || clk_en || sample_valid) strobes++;
        end
        chk("disabled_strobes", strobes, 0);
        chk("disabled_hold_out", sample_out, 69);
        chk("expected_queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err + m_err, n_chk + m_chk);
        $finish;
    end

endmodule
